uart_rx_fsm: RTL and testbench
==============================

Name: uart_rx_fsm

Overview:
Receive-side frame controller for the UART Rx path. It detects the start bit and walks the frame through start, data, optional parity and stop. It owns the per-bit edge counter and the bit counter, and generates the enables for the data sampler, start/parity/stop checkers and deserializer. It consumes the checker error flags and issues a one-cycle Data_Valid or Rx_Err at end of frame.

Parameters:
WIDTH, 8, data bits per frame (1..15)
PRESCALE_WIDTH, 5, width of Prescale and Edge_Cnt

Ports:
CLK  input  1  clock
RST  input  1  asynchronous reset, active-low
RX_IN  input  1  serial line, already synchronised, idle high
PAR_EN  input  1  1 = frame carries a parity bit
Prescale  input  PRESCALE_WIDTH  clocks per bit; even, >=8; static while a frame is in progress
Strt_Glitch  input  1  registered start-check result from start checker
Par_Err  input  1  registered parity-check result from parity checker
Stp_Err  input  1  registered stop-check result from stop checker
Edge_Cnt  output  PRESCALE_WIDTH  clock index within current bit, 0..Prescale-1
Bit_Cnt  output  4  data-bit index within DATA state, 0..WIDTH-1
Dat_Samp_En  output  1  sampler enable
Strt_Chk_En  output  1  start checker enable
Par_Chk_En  output  1  parity checker enable
Stp_Chk_En  output  1  stop checker enable
Deser_En  output  1  one-cycle shift strobe to deserializer
Data_Valid  output  1  one-cycle pulse, good frame received
Rx_Err  output  1  one-cycle pulse, frame rejected (parity or stop error)

Behaviour:
- States: IDLE, START, DATA, PARITY, STOP. Registered state and counters; enables decoded from the registered state.
- Reset (RST low, any time including mid-frame): state IDLE, Edge_Cnt=0, Bit_Cnt=0, all enables 0, Data_Valid=0, Rx_Err=0.
- Define CHK = (Prescale>>1)+2 and END = Prescale-1.
- Edge_Cnt:
  - Held at 0 in IDLE.
  - In other states, increments every cycle and wraps END->0.
  - First cycle of START has Edge_Cnt=0.
- IDLE:
  - RX_IN==0 -> START.
  - PAR_EN is latched into an internal par_en_q on this transition; par_en_q governs the whole frame.
- START:
  - Strt_Chk_En=1.
  - At Edge_Cnt==END: Strt_Glitch=1 -> IDLE (no Data_Valid, no Rx_Err); otherwise -> DATA with Bit_Cnt=0.
- DATA:
  - Deser_En=1 only on cycles where Edge_Cnt==CHK.
  - At END: if Bit_Cnt==WIDTH-1, go to PARITY when par_en_q=1, else STOP; otherwise Bit_Cnt+1.
- PARITY:
  - Par_Chk_En=1.
  - At END -> STOP.
- STOP:
  - Stp_Chk_En=1.
  - At END -> IDLE.
  - On the same edge, register the frame result:
    - Data_Valid=1 if Stp_Err==0 and (par_en_q==0 or Par_Err==0).
    - Otherwise Rx_Err=1.
  - Exactly one of Data_Valid/Rx_Err pulses, visible for the first IDLE cycle only.
- Dat_Samp_En=1 in every state except IDLE.
- Error flags are sampled only at END, after the checkers' CHK update. A stale Par_Err is ignored when par_en_q=0.
- Bit_Cnt holds its value outside DATA and is cleared on entry to DATA.
- PAR_EN changes mid-frame have no effect. Prescale changes mid-frame are unsupported.
- RX_IN low in the first IDLE cycle after STOP starts a new frame immediately, giving back-to-back frames with no idle gap.
- Frame length: (WIDTH+2+par_en_q)*Prescale cycles from START entry to IDLE re-entry.

Test Plan:
1. Prescale=8, PAR_EN=1, 0xA5 LSB-first with parity bit 0; checker flags all 0.
   -> Deser_En strobes at Edge_Cnt=6 in each of 8 data bits.
   -> Data_Valid=1 exactly 88 cycles after START entry, for 1 cycle; Rx_Err stays 0.
2. Prescale=16, PAR_EN=0, 0x3C.
   -> No PARITY state and Par_Chk_En never 1.
   -> Data_Valid pulses 160 cycles after START entry, even with Par_Err held 1.
3. RX_IN low for 2 cycles, Strt_Glitch=1 at START Edge_Cnt=7 (Prescale=8).
   -> Returns to IDLE after 8 cycles; no Deser_En, Data_Valid or Rx_Err.
4. PAR_EN=1, Par_Err=1 when STOP ends.
   -> Rx_Err=1 for 1 cycle, Data_Valid=0.
   Repeat with PAR_EN=1, Par_Err=0, Stp_Err=1 -> Rx_Err=1, Data_Valid=0.
5. Two back-to-back frames 0x01 and 0xFF, RX_IN falls on the first IDLE cycle.
   -> Second START entered on the next cycle; two Data_Valid pulses spaced exactly one frame length apart.
6. Assert RST low at DATA, Bit_Cnt=3.
   -> All outputs 0 and state IDLE immediately (asynchronous).
   -> After release, the next falling RX_IN starts a clean frame with Edge_Cnt=0.

Source files
------------

// File: rtl/uart_rx_fsm_if.sv
// Bundle between the UART Rx frame controller and its datapath: serial line,
// frame configuration, checker results in; counters, enables and frame result out.
interface uart_rx_fsm_if #(
    parameter int PRESCALE_WIDTH = 5
);
    logic                      RX_IN;
    logic                      PAR_EN;
    logic [PRESCALE_WIDTH-1:0] Prescale;
    logic                      Strt_Glitch;
    logic                      Par_Err;
    logic                      Stp_Err;

    logic [PRESCALE_WIDTH-1:0] Edge_Cnt;
    logic [3:0]                Bit_Cnt;
    logic                      Dat_Samp_En;
    logic                      Strt_Chk_En;
    logic                      Par_Chk_En;
    logic                      Stp_Chk_En;
    logic                      Deser_En;
    logic                      Data_Valid;
    logic                      Rx_Err;

    // Frame controller side
    modport master (
        input  RX_IN, PAR_EN, Prescale, Strt_Glitch, Par_Err, Stp_Err,
        output Edge_Cnt, Bit_Cnt, Dat_Samp_En, Strt_Chk_En, Par_Chk_En,
               Stp_Chk_En, Deser_En, Data_Valid, Rx_Err
    );

    // Datapath / environment side
    modport slave (
        output RX_IN, PAR_EN, Prescale, Strt_Glitch, Par_Err, Stp_Err,
        input  Edge_Cnt, Bit_Cnt, Dat_Samp_En, Strt_Chk_En, Par_Chk_En,
               Stp_Chk_En, Deser_En, Data_Valid, Rx_Err
    );
endinterface

// File: rtl/uart_rx_fsm.sv
// UART Rx frame controller: walks START/DATA/PARITY/STOP, owns the edge and bit
// counters, drives checker/deserializer enables and reports the frame result.
module uart_rx_fsm #(
    parameter int WIDTH          = 8,
    parameter int PRESCALE_WIDTH = 5
) (
    input  logic          CLK,
    input  logic          RST,
    uart_rx_fsm_if.master bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [3:0]                LAST_BIT = 4'(WIDTH - 1);
    localparam logic [3:0]                BIT_ZERO = 4'b0000;
    localparam logic [3:0]                BIT_ONE  = 4'b0001;
    localparam logic [PRESCALE_WIDTH-1:0] PS_ZERO  = {PRESCALE_WIDTH{1'b0}};
    localparam logic [PRESCALE_WIDTH-1:0] PS_ONE   = {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PRESCALE_WIDTH:0]   CHK_OFS  = {{(PRESCALE_WIDTH-1){1'b0}}, 2'b10};

    // A frame is good when the stop bit is clean and parity, if carried, is clean.
    function automatic logic frame_ok(input logic stp_err, input logic par_err,
                                      input logic par_used);
        return !stp_err && (!par_used || !par_err);
    endfunction

    state_t                    r_state;
    logic [PRESCALE_WIDTH-1:0] r_edge_cnt;
    logic [3:0]                r_bit_cnt;
    logic                      r_par_en_q;
    logic                      r_dat_samp_en;
    logic                      r_strt_chk_en;
    logic                      r_par_chk_en;
    logic                      r_stp_chk_en;
    logic                      r_deser_en;
    logic                      r_data_valid;
    logic                      r_rx_err;

    state_t                    w_next_state;
    logic [PRESCALE_WIDTH-1:0] w_next_edge;
    logic [3:0]                w_next_bit;
    logic                      w_next_par_en;
    logic                      w_frame_end;
    logic                      w_frame_ok;
    logic [PRESCALE_WIDTH-1:0] w_end;
    logic [PRESCALE_WIDTH:0]   w_chk;
    logic                      w_at_end;

    // CHK is one bit wider so (Prescale>>1)+2 never wraps for the largest Prescale.
    assign w_end      = bus.Prescale - PS_ONE;
    assign w_chk      = {1'b0, 1'b0, bus.Prescale[PRESCALE_WIDTH-1:1]} + CHK_OFS;
    assign w_at_end   = (r_edge_cnt == w_end);
    assign w_frame_ok = frame_ok(bus.Stp_Err, bus.Par_Err, r_par_en_q);

    // Next-state, next-counter and end-of-frame decode from the registered state.
    always_comb begin
        w_next_state  = r_state;
        w_next_edge   = PS_ZERO;
        w_next_bit    = r_bit_cnt;
        w_next_par_en = r_par_en_q;
        w_frame_end   = 1'b0;

        if ((r_state == IDLE) || w_at_end) begin
            w_next_edge = PS_ZERO;
        end else begin
            w_next_edge = r_edge_cnt + PS_ONE;
        end

        case (r_state)
            IDLE: begin
                if (!bus.RX_IN) begin
                    w_next_state  = START;
                    w_next_par_en = bus.PAR_EN;
                end else begin
                    w_next_state  = IDLE;
                end
            end
            START: begin
                if (w_at_end) begin
                    if (bus.Strt_Glitch) begin
                        w_next_state = IDLE;
                    end else begin
                        w_next_state = DATA;
                        w_next_bit   = BIT_ZERO;
                    end
                end else begin
                    w_next_state = START;
                end
            end
            DATA: begin
                if (w_at_end) begin
                    if (r_bit_cnt == LAST_BIT) begin
                        w_next_state = r_par_en_q ? PARITY : STOP;
                    end else begin
                        w_next_bit   = r_bit_cnt + BIT_ONE;
                    end
                end else begin
                    w_next_state = DATA;
                end
            end
            PARITY: begin
                if (w_at_end) begin
                    w_next_state = STOP;
                end else begin
                    w_next_state = PARITY;
                end
            end
            STOP: begin
                if (w_at_end) begin
                    w_next_state = IDLE;
                    w_frame_end  = 1'b1;
                end else begin
                    w_next_state = STOP;
                end
            end
            default: begin
                w_next_state = IDLE;
                w_next_edge  = PS_ZERO;
            end
        endcase
    end

    // State, counters and all outputs registered together; enables follow the next state
    // so they line up with the state they belong to.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state       <= IDLE;
            r_edge_cnt    <= PS_ZERO;
            r_bit_cnt     <= BIT_ZERO;
            r_par_en_q    <= 1'b0;
            r_dat_samp_en <= 1'b0;
            r_strt_chk_en <= 1'b0;
            r_par_chk_en  <= 1'b0;
            r_stp_chk_en  <= 1'b0;
            r_deser_en    <= 1'b0;
            r_data_valid  <= 1'b0;
            r_rx_err      <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_edge_cnt    <= w_next_edge;
            r_bit_cnt     <= w_next_bit;
            r_par_en_q    <= w_next_par_en;
            r_dat_samp_en <= (w_next_state != IDLE);
            r_strt_chk_en <= (w_next_state == START);
            r_par_chk_en  <= (w_next_state == PARITY);
            r_stp_chk_en  <= (w_next_state == STOP);
            r_deser_en    <= (w_next_state == DATA) && ({1'b0, w_next_edge} == w_chk);
            r_data_valid  <= w_frame_end && w_frame_ok;
            r_rx_err      <= w_frame_end && !w_frame_ok;
        end
    end

    assign bus.Edge_Cnt    = r_edge_cnt;
    assign bus.Bit_Cnt     = r_bit_cnt;
    assign bus.Dat_Samp_En = r_dat_samp_en;
    assign bus.Strt_Chk_En = r_strt_chk_en;
    assign bus.Par_Chk_En  = r_par_chk_en;
    assign bus.Stp_Chk_En  = r_stp_chk_en;
    assign bus.Deser_En    = r_deser_en;
    assign bus.Data_Valid  = r_data_valid;
    assign bus.Rx_Err      = r_rx_err;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Scoreboard bench for uart_rx_fsm: directed frames push expected results,
// a negedge monitor pops and compares whenever Data_Valid or Rx_Err fires.
module tb_uart_rx_fsm;
    localparam int PW = 5;
    localparam int W  = 8;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    uart_rx_fsm_if #(.PRESCALE_WIDTH(PW)) bus ();

    uart_rx_fsm #(.WIDTH(W), .PRESCALE_WIDTH(PW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct {
        bit         is_err;
        int         cyc;
        logic [7:0] data;
        int         deser_n;
        int         par_n;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    int         cur_p  = 8;
    int         deser_n = 0;
    int         par_n   = 0;
    logic [7:0] shreg   = 8'h00;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: strobe placement, data assembly and frame results
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (!RST) begin
                deser_n = 0;
                par_n   = 0;
                shreg   = 8'h00;
            end else begin
                if (bus.Deser_En) begin
                    deser_n++;
                    shreg = {bus.RX_IN, shreg[7:1]};
                    check("deser_edge", 32'(bus.Edge_Cnt), 32'((cur_p >> 1) + 2));
                end
                if (bus.Par_Chk_En) par_n++;
                if (bus.Data_Valid || bus.Rx_Err) begin
                    if (sb.size() == 0) begin
                        check("unexpected_pulse", 32'({bus.Data_Valid, bus.Rx_Err}), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("result_kind", 32'({bus.Data_Valid, bus.Rx_Err}),
                              e.is_err ? 32'd1 : 32'd2);
                        check("result_cycle", 32'(cyc), 32'(e.cyc));
                        check("deser_count", 32'(deser_n), 32'(e.deser_n));
                        check("par_chk_cycles", 32'(par_n), 32'(e.par_n));
                        if (!e.is_err) check("data", 32'(shreg), 32'(e.data));
                    end
                    deser_n = 0;
                    par_n   = 0;
                end
            end
        end
    end

    // Drive one frame starting in the current cycle; returns in the first IDLE cycle after STOP.
    task automatic send_frame(input logic [7:0] d, input bit pe, input bit pbit,
                              input bit perr, input bit serr, input int p);
        exp_t        e;
        int          start;
        int          nb;
        logic [15:0] bits;
        cur_p           = p;
        bus.Prescale    = PW'(p);
        bus.PAR_EN      = pe;
        bus.Par_Err     = perr;
        bus.Stp_Err     = serr;
        bus.Strt_Glitch = 1'b0;
        bus.RX_IN       = 1'b0;
        start     = cyc + 1;
        e.is_err  = serr || (pe && perr);
        e.cyc     = start + (W + 2 + int'(pe)) * p;
        e.data    = d;
        e.deser_n = W;
        e.par_n   = pe ? p : 0;
        sb.push_back(e);
        bits = 16'h0000;
        for (int i = 0; i < W; i++) bits[1 + i] = d[i];
        nb = 1 + W;
        if (pe) begin
            bits[nb] = pbit;
            nb++;
        end
        bits[nb] = 1'b1;
        nb++;
        @(posedge CLK); #1;
        check("start_edge0", 32'(bus.Edge_Cnt), 32'd0);
        check("start_chk_en", 32'(bus.Strt_Chk_En), 32'd1);
        bus.PAR_EN = ~pe;
        for (int k = 0; k < nb; k++) begin
            bus.RX_IN = bits[k];
            repeat (p) @(posedge CLK);
            #1;
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int start;
        logic [7:0] ad;
        bus.RX_IN       = 1'b1;
        bus.PAR_EN      = 1'b0;
        bus.Prescale    = PW'(8);
        bus.Strt_Glitch = 1'b0;
        bus.Par_Err     = 1'b0;
        bus.Stp_Err     = 1'b0;

        // Reset state
        idle_cycles(2);
        check("reset_outputs", 32'({bus.Edge_Cnt, bus.Bit_Cnt, bus.Dat_Samp_En, bus.Strt_Chk_En,
              bus.Par_Chk_En, bus.Stp_Chk_En, bus.Deser_En, bus.Data_Valid, bus.Rx_Err}), 32'd0);
        RST = 1'b1;
        idle_cycles(3);

        // Parity frame, Prescale 8: result 88 cycles after START entry
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 8);
        idle_cycles(3);

        // No parity, Prescale 16, stale Par_Err ignored, PAR_EN flipped mid-frame
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 16);
        bus.Par_Err = 1'b0;
        idle_cycles(3);

        // False start: glitch reported at the end of START
        cur_p = 8;
        bus.Prescale = PW'(8);
        bus.RX_IN    = 1'b0;
        start = cyc + 1;
        idle_cycles(1);
        idle_cycles(1);
        bus.RX_IN = 1'b1;
        idle_cycles(6);
        check("glitch_cycle", 32'(cyc), 32'(start + 7));
        bus.Strt_Glitch = 1'b1;
        check("glitch_samp_en_before", 32'(bus.Dat_Samp_En), 32'd1);
        idle_cycles(1);
        check("glitch_idle", 32'({bus.Dat_Samp_En, bus.Strt_Chk_En, bus.Edge_Cnt}), 32'd0);
        check("glitch_no_deser", 32'(deser_n), 32'd0);
        bus.Strt_Glitch = 1'b0;
        idle_cycles(3);

        // Parity error, then stop error
        send_frame(8'h0F, 1'b1, 1'b0, 1'b1, 1'b0, 8);
        bus.Par_Err = 1'b0;
        idle_cycles(3);
        send_frame(8'h96, 1'b1, 1'b0, 1'b0, 1'b1, 8);
        bus.Stp_Err = 1'b0;
        idle_cycles(3);

        // Back-to-back frames with no idle gap
        send_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 8);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 8);
        idle_cycles(3);

        // Asynchronous reset in DATA at Bit_Cnt 3, then a clean frame
        ad = 8'h5A;
        cur_p = 8;
        bus.Prescale = PW'(8);
        bus.PAR_EN   = 1'b1;
        bus.RX_IN    = 1'b0;
        idle_cycles(1);
        idle_cycles(8);
        for (int i = 0; i < 3; i++) begin
            bus.RX_IN = ad[i];
            idle_cycles(8);
        end
        bus.RX_IN = ad[3];
        idle_cycles(2);
        check("abort_bit_cnt", 32'(bus.Bit_Cnt), 32'd3);
        check("abort_edge_cnt", 32'(bus.Edge_Cnt), 32'd2);
        #2 RST = 1'b0;
        #1;
        check("async_reset_outputs", 32'({bus.Edge_Cnt, bus.Bit_Cnt, bus.Dat_Samp_En,
              bus.Strt_Chk_En, bus.Par_Chk_En, bus.Stp_Chk_En, bus.Deser_En, bus.Data_Valid,
              bus.Rx_Err}), 32'd0);
        bus.RX_IN = 1'b1;
        idle_cycles(2);
        RST = 1'b1;
        idle_cycles(3);
        check("post_reset_idle", 32'(bus.Dat_Samp_En), 32'd0);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 8);
        idle_cycles(5);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
